// File: rtl/step_watchdog_pkg.sv
// Shared types and helpers for the step-activity watchdog.
package step_watchdog_pkg;

    typedef enum logic [1:0] {
        WD_DISARMED = 2'd0,
        WD_ARMED    = 2'd1,
        WD_TRIPPED  = 2'd2
    } wd_state_e;

    // Idle timeout expressed in clock cycles.
    function automatic longint wd_limit(input longint hz, input longint timeout_s);
        return hz * timeout_s;
    endfunction

endpackage

// File: rtl/step_idle_counter.sv
// One step channel: toggle detect, saturating idle counter and registered stale flag.
module step_idle_counter #(
    parameter int unsigned           CNT_BITS = 32,
    parameter logic [CNT_BITS-1:0]   LIMIT    = '1,
    parameter bit                    DBG_EN   = 1'b0
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       step_i,
    output logic       stale_o,
    output logic [7:0] dbg_o
);

    logic                prev_q;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                stale_q;
    logic                edge_w;

    assign edge_w = step_i ^ prev_q;

    // An edge always beats saturation; the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_w)
            cnt_d = '0;
        else if (cnt_q != LIMIT)
            cnt_d = cnt_q + CNT_BITS'(1);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            prev_q  <= step_i;
            cnt_q   <= cnt_d;
            stale_q <= (cnt_q == LIMIT) && !edge_w;
        end
    end

    assign stale_o = stale_q;
    assign dbg_o   = DBG_EN ? cnt_q[CNT_BITS-1 -: 8] : 8'h00;

endmodule

// File: rtl/step_watchdog.sv
// Step-activity watchdog: per-channel idle timers, arm synchroniser and a sticky
// shutdown request once any guarded channel has been idle for the timeout.
//
//   state       | meaning
//   WD_DISARMED | counters run, staleness ignored
//   WD_ARMED    | any guarded stale channel trips
//   WD_TRIPPED  | req_shutdown latched until clr
module step_watchdog
    import step_watchdog_pkg::*;
#(
    parameter int unsigned          NSTEPDIR   = 6,
    parameter int unsigned          HZ         = 48000000,
    parameter int unsigned          TIMEOUT_S  = 10,
    parameter int unsigned          CNT_BITS   = 32,
    parameter logic [NSTEPDIR-1:0]  GUARD_MASK = 6'b100000,
    parameter int unsigned          DBG_CHAN   = 5
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NSTEPDIR-1:0] step,
    input  logic                arm_n,
    output logic [NSTEPDIR-1:0] stale,
    output logic                armed,
    output logic                req_shutdown,
    output logic [2:0]          trip_chan,
    output logic [7:0]          idle_dbg
);

    localparam longint              LIMIT_L = wd_limit(longint'(HZ), longint'(TIMEOUT_S));
    localparam logic [CNT_BITS-1:0] LIMIT   = LIMIT_L[CNT_BITS-1:0];

    logic [NSTEPDIR-1:0] stale_w;
    logic [7:0]          dbg_w [NSTEPDIR];

    for (genvar i = 0; i < NSTEPDIR; i++) begin : g_chan
        step_idle_counter #(
            .CNT_BITS (CNT_BITS),
            .LIMIT    (LIMIT),
            .DBG_EN   (i == DBG_CHAN)
        ) u_cnt (
            .clk_i   (clk),
            .clr_i   (clr),
            .step_i  (step[i]),
            .stale_o (stale_w[i]),
            .dbg_o   (dbg_w[i])
        );
    end

    logic          arm_meta_q, arm_sync_q;
    wd_state_e     state_q, state_d;
    logic          armed_q, req_q;
    logic [2:0]    trip_chan_q, trip_chan_d;
    logic [7:0]    idle_dbg_q, idle_dbg_d;
    logic [NSTEPDIR-1:0] guarded_w;

    assign guarded_w = stale_w & GUARD_MASK;

    always_comb begin
        state_d     = state_q;
        trip_chan_d = trip_chan_q;
        case (state_q)
            WD_DISARMED: if (!arm_sync_q) state_d = WD_ARMED;
            WD_ARMED: begin
                if (|guarded_w) begin
                    state_d = WD_TRIPPED;
                    // Descending scan so the lowest guarded index wins.
                    for (int i = NSTEPDIR - 1; i >= 0; i--)
                        if (guarded_w[i]) trip_chan_d = 3'(i);
                end
            end
            WD_TRIPPED:  state_d = WD_TRIPPED;
            default:     state_d = WD_DISARMED;
        endcase
    end

    // Only the DBG_CHAN instance drives a non-zero byte.
    always_comb begin
        idle_dbg_d = 8'h00;
        for (int i = 0; i < NSTEPDIR; i++)
            idle_dbg_d = idle_dbg_d | dbg_w[i];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            arm_meta_q  <= 1'b1;
            arm_sync_q  <= 1'b1;
            state_q     <= WD_DISARMED;
            armed_q     <= 1'b0;
            req_q       <= 1'b0;
            trip_chan_q <= 3'd0;
            idle_dbg_q  <= 8'h00;
        end else begin
            arm_meta_q  <= arm_n;
            arm_sync_q  <= arm_meta_q;
            state_q     <= state_d;
            armed_q     <= (state_d != WD_DISARMED);
            req_q       <= (state_d == WD_TRIPPED);
            trip_chan_q <= trip_chan_d;
            idle_dbg_q  <= idle_dbg_d;
        end
    end

    assign stale        = stale_w;
    assign armed        = armed_q;
    assign req_shutdown = req_q;
    assign trip_chan    = trip_chan_q;
    assign idle_dbg     = idle_dbg_q;

endmodule

// File: tb/tb_step_watchdog.sv
// Directed bench for step_watchdog with LIMIT = 100 cycles; a second instance
// guards ch2 and ch5 for the simultaneous-trip case.
module tb_step_watchdog;

    logic       clk = 1'b0;
    logic       clr;
    logic       arm_n;
    logic [5:0] step;

    logic [5:0] stale,  stale2;
    logic       armed,  armed2;
    logic       req,    req2;
    logic [2:0] trip,   trip2;
    logic [7:0] dbg,    dbg2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    step_watchdog #(
        .NSTEPDIR(6), .HZ(100), .TIMEOUT_S(1), .CNT_BITS(8),
        .GUARD_MASK(6'b100000), .DBG_CHAN(5)
    ) dut (
        .clk(clk), .clr(clr), .step(step), .arm_n(arm_n),
        .stale(stale), .armed(armed), .req_shutdown(req),
        .trip_chan(trip), .idle_dbg(dbg)
    );

    step_watchdog #(
        .NSTEPDIR(6), .HZ(100), .TIMEOUT_S(1), .CNT_BITS(8),
        .GUARD_MASK(6'b100100), .DBG_CHAN(5)
    ) dut2 (
        .clk(clk), .clr(clr), .step(step), .arm_n(arm_n),
        .stale(stale2), .armed(armed2), .req_shutdown(req2),
        .trip_chan(trip2), .idle_dbg(dbg2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves time just after the last reset edge (P0) with clr released.
    task automatic do_reset(input logic [5:0] s);
        step  = s;
        arm_n = 1'b1;
        clr   = 1'b1;
        tick(2);
        clr   = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(6'h3F);
        n_tests++;
        if ({stale, armed, req, trip, dbg} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {stale, armed, req, trip, dbg});
        end
        // step held high through reset counts as an edge at P1
        tick(2);
        n_tests++;
        if (dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_first_edge_p2: dbg got %0d expected 0", dbg);
        end
        tick(1);
        n_tests++;
        if (dbg !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_first_edge_p3: dbg got %0d expected 1", dbg);
        end
    endtask

    task automatic test_stale_unarmed;
        do_reset(6'h00);
        tick(9);
        step[5] = 1'b1;
        tick(1);
        tick(100);
        n_tests++;
        if (stale[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_early: got %b expected 0", stale[5]);
        end
        tick(1);
        n_tests++;
        if (stale[5] !== 1'b1 || dbg !== 8'd100) begin
            n_fail++;
            $display("FAIL stale_rise: stale5 %b dbg %0d expected 1 100", stale[5], dbg);
        end
        n_tests++;
        if (req !== 1'b0 || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL unarmed_no_trip: req %b armed %b expected 0 0", req, armed);
        end
        tick(38);
        step[5] = 1'b0;
        tick(1);
        n_tests++;
        if (stale[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_clear: got %b expected 0", stale[5]);
        end
        tick(1);
        n_tests++;
        if (dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL stale_clear_cnt: dbg got %0d expected 0", dbg);
        end
    endtask

    task automatic test_arm_trip;
        do_reset(6'h00);
        arm_n = 1'b0;
        tick(2);
        n_tests++;
        if (armed !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_early: got %b expected 0", armed);
        end
        tick(1);
        n_tests++;
        if (armed !== 1'b1 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_latency: armed %b req %b expected 1 0", armed, req);
        end
        tick(98);
        n_tests++;
        if (stale[5] !== 1'b1 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL trip_pre: stale5 %b req %b expected 1 0", stale[5], req);
        end
        tick(1);
        n_tests++;
        if (req !== 1'b1 || trip !== 3'd5 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL trip: req %b trip %0d armed %b expected 1 5 1", req, trip, armed);
        end
        step[5] = 1'b1;
        arm_n   = 1'b1;
        tick(1);
        n_tests++;
        if (stale[5] !== 1'b0 || req !== 1'b1) begin
            n_fail++;
            $display("FAIL trip_sticky: stale5 %b req %b expected 0 1", stale[5], req);
        end
        tick(5);
        n_tests++;
        if (req !== 1'b1 || trip !== 3'd5 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL trip_hold: req %b trip %0d armed %b expected 1 5 1", req, trip, armed);
        end
    endtask

    task automatic test_unguarded;
        logic seen_req;
        do_reset(6'h00);
        arm_n    = 1'b0;
        seen_req = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c % 50 == 0) step[5] = ~step[5];
            tick(1);
            seen_req = seen_req | req;
        end
        n_tests++;
        if (stale !== 6'b011111) begin
            n_fail++;
            $display("FAIL unguarded_stale: got %b expected 011111", stale);
        end
        n_tests++;
        if (seen_req !== 1'b0 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL unguarded_no_trip: seen_req %b armed %b expected 0 1", seen_req, armed);
        end
    endtask

    task automatic test_simultaneous;
        do_reset(6'h00);
        arm_n = 1'b0;
        tick(101);
        n_tests++;
        if (stale2[5] !== 1'b1 || stale2[2] !== 1'b1 || req2 !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_pre: stale2 %b req2 %b expected 1x1xx 0", stale2, req2);
        end
        tick(1);
        n_tests++;
        if (req2 !== 1'b1 || trip2 !== 3'd2) begin
            n_fail++;
            $display("FAIL simul_trip_chan: req2 %b trip2 %0d expected 1 2", req2, trip2);
        end
        n_tests++;
        if (trip !== 3'd5) begin
            n_fail++;
            $display("FAIL simul_single_guard: trip %0d expected 5", trip);
        end
    endtask

    task automatic test_saturation_race;
        do_reset(6'h00);
        tick(100);
        n_tests++;
        if (dbg !== 8'd99 || stale[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL race_pre: dbg %0d stale5 %b expected 99 0", dbg, stale[5]);
        end
        step[5] = 1'b1;
        tick(1);
        n_tests++;
        if (stale[5] !== 1'b0 || dbg !== 8'd100) begin
            n_fail++;
            $display("FAIL race_edge: stale5 %b dbg %0d expected 0 100", stale[5], dbg);
        end
        tick(1);
        n_tests++;
        if (stale[5] !== 1'b0 || dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL race_after: stale5 %b dbg %0d expected 0 0", stale[5], dbg);
        end
        tick(50);
        n_tests++;
        if (stale[5] !== 1'b0 || dbg !== 8'd50) begin
            n_fail++;
            $display("FAIL race_later: stale5 %b dbg %0d expected 0 50", stale[5], dbg);
        end
    endtask

    task automatic test_reset_while_tripped;
        do_reset(6'h00);
        arm_n = 1'b0;
        tick(102);
        n_tests++;
        if (req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_trip_pre: req %b expected 1", req);
        end
        clr   = 1'b1;
        arm_n = 1'b1;
        tick(1);
        clr   = 1'b0;
        n_tests++;
        if ({stale, armed, req, trip, dbg} !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_trip_outputs: got %h expected 0", {stale, armed, req, trip, dbg});
        end
        tick(5);
        n_tests++;
        if (armed !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_trip_stay_disarmed: armed %b req %b expected 0 0", armed, req);
        end
        arm_n = 1'b0;
        tick(2);
        n_tests++;
        if (armed !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_early: armed %b expected 0", armed);
        end
        tick(1);
        n_tests++;
        if (armed !== 1'b1 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm: armed %b req %b expected 1 0", armed, req);
        end
    endtask

    initial begin
        clr   = 1'b1;
        arm_n = 1'b1;
        step  = 6'h00;
        test_reset();
        test_stale_unarmed();
        test_arm_trip();
        test_unguarded();
        test_simultaneous();
        test_saturation_race();
        test_reset_while_tripped();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
